// File: rtl/mem_pkg.sv
// Shared definitions for the parametrised processor memory: bus direction codes,
// controller state encoding and the default geometry used by the processor top level.
package mem_pkg;

  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_state_t;

  localparam int MEM_DATA_W = 256;
  localparam int MEM_ADDR_W = 7;
  localparam int MEM_DEPTH  = 128;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: RD_LAT stages carrying valid, address-error flag and data.
// The last stage is the DataOut/ReadValid register and holds its value between reads.
module mem_rd_pipe #(
  parameter int DATA_W = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic [RD_LAT-1:0] vld_q, err_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  logic [RD_LAT-1:0] vld_chain, err_chain;
  logic [DATA_W-1:0] dat_chain [RD_LAT];

  // Input of stage i is the output of stage i-1; stage 0 takes the accepted request.
  always_comb begin
    vld_chain    = RD_LAT'({vld_q, vld_i});
    err_chain    = RD_LAT'({err_q, err_i});
    dat_chain[0] = data_i;
    for (int i = 1; i < RD_LAT; i++) dat_chain[i] = dat_q[i-1];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) begin
      if (vld_chain[i]) begin
        dat_q[i] <= dat_chain[i];
        err_q[i] <= err_chain[i];
      end
    end
    if (!rst_n) begin
      vld_q               <= '0;
      err_q[RD_LAT-1]     <= 1'b0;
      dat_q[RD_LAT-1]     <= '0;
    end else begin
      vld_q <= vld_chain;
    end
  end

  // An out-of-range read still returns a beat, but with zero data.
  assign vld_o  = vld_q[RD_LAT-1];
  assign data_o = err_q[RD_LAT-1] ? '0 : dat_q[RD_LAT-1];

endmodule

// File: rtl/sram_mem_param.sv
// Parametrised single-port synchronous SRAM with byte enables, request handshake,
// post-reset clear sequence and out-of-range address detection.
module sram_mem_param
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                MemEnable,
  input  logic                MemReadWrite,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [DATA_W-1:0]   DataIn,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic                MemReady,
  output logic [DATA_W-1:0]   DataOut,
  output logic                ReadValid,
  output logic                WriteDone,
  output logic                AddrError
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  mem_state_t        state_q, state_d;
  logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
  logic              wr_done_q, addr_err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic             accept, in_range, wr_acc, rd_acc;
  logic [IDX_W-1:0] idx;

  always_comb begin
    in_range = {1'b0, Address} < DEPTH_A;
    accept   = MemEnable & (state_q == RUN);
    wr_acc   = accept & (MemReadWrite == MEM_WR) & in_range;
    rd_acc   = accept & (MemReadWrite == MEM_RD);
    idx      = Address[IDX_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + IDX_W'(1);
        if (init_cnt_q == LAST_IDX) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
      end
      RUN:     ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      wr_done_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wr_done_q  <= wr_acc;
      addr_err_q <= accept & ~in_range;
    end
  end

  // Storage: cleared one word per cycle in INIT, byte-merged writes in RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT) mem_q[init_cnt_q] <= '0;
      else if (wr_acc)     mem_q[idx] <= byte_merge(mem_q[idx], DataIn, ByteEn);
    end
  end

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (rd_acc),
    .err_i  (~in_range),
    .data_i (mem_q[idx]),
    .vld_o  (ReadValid),
    .data_o (DataOut)
  );

  assign MemReady  = (state_q == RUN);
  assign WriteDone = wr_done_q;
  assign AddrError = addr_err_q;

endmodule

// File: tb/tb_sram_mem_param.sv
// Bench for sram_mem_param: three configurations driven by directed requests,
// with expected responses queued at issue time and checked by a cycle-accurate monitor.
module tb_sram_mem_param;

  logic         clk = 1'b0;
  logic [2:0]   rst_n;
  logic [2:0]   en;
  logic         rw;
  logic [6:0]   addr;
  logic [255:0] din;
  logic [31:0]  be;
  logic [2:0]   rdy, rv, wd, ae;
  logic [255:0] dout [3];

  int cyc = 0;
  int nvec, nerr;
  bit mon_en;
  logic [255:0] last [3];

  typedef struct { int inst; int due; logic [255:0] data; } rd_t;
  typedef struct { int inst; int due; logic wd; logic ae; } ack_t;
  rd_t  rdq [$];
  ack_t ackq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_mem_param #(.DATA_W(256), .ADDR_W(7), .DEPTH(128), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .MemEnable(en[0]), .MemReadWrite(rw), .Address(addr),
    .DataIn(din), .ByteEn(be), .MemReady(rdy[0]), .DataOut(dout[0]), .ReadValid(rv[0]),
    .WriteDone(wd[0]), .AddrError(ae[0]));

  sram_mem_param #(.DATA_W(256), .ADDR_W(7), .DEPTH(100), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .MemEnable(en[1]), .MemReadWrite(rw), .Address(addr),
    .DataIn(din), .ByteEn(be), .MemReady(rdy[1]), .DataOut(dout[1]), .ReadValid(rv[1]),
    .WriteDone(wd[1]), .AddrError(ae[1]));

  sram_mem_param #(.DATA_W(256), .ADDR_W(7), .DEPTH(16), .RD_LAT(4)) dut_c (
    .clk(clk), .rst_n(rst_n[2]), .MemEnable(en[2]), .MemReadWrite(rw), .Address(addr),
    .DataIn(din), .ByteEn(be), .MemReady(rdy[2]), .DataOut(dout[2]), .ReadValid(rv[2]),
    .WriteDone(wd[2]), .AddrError(ae[2]));

  function automatic int dep(input int k);
    case (k)
      0:       return 128;
      1:       return 100;
      default: return 16;
    endcase
  endfunction

  function automatic int lat(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle, each instance either presents a due response or stays idle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        int hit;
        hit = -1;
        foreach (rdq[i]) if (rdq[i].inst == k && rdq[i].due == cyc) hit = i;
        if (hit >= 0) begin
          chk("read_valid", k, rv[k], 1);
          chk("read_data", k, dout[k], rdq[hit].data);
          last[k] = rdq[hit].data;
          rdq.delete(hit);
        end else begin
          chk("rv_idle", k, rv[k], 0);
          chk("dout_hold", k, dout[k], last[k]);
        end
        hit = -1;
        foreach (ackq[i]) if (ackq[i].inst == k && ackq[i].due == cyc) hit = i;
        if (hit >= 0) begin
          chk("write_done", k, wd[k], ackq[hit].wd);
          chk("addr_error", k, ae[k], ackq[hit].ae);
          ackq.delete(hit);
        end else begin
          chk("ack_idle", k, {wd[k], ae[k]}, 0);
        end
      end
    end
  end

  // Issue one request in the next cycle and queue the responses it must produce.
  task automatic req(input int k, input logic rwv, input logic [6:0] a, input logic [255:0] d,
                     input logic [31:0] b, input logic [255:0] exp);
    logic inr;
    ack_t ac;
    rd_t  rr;
    @(posedge clk); #2;
    en = '0; en[k] = 1'b1; rw = rwv; addr = a; din = d; be = b;
    chk("ready", k, rdy[k], 1);
    inr = (int'(a) < dep(k));
    ac.inst = k; ac.due = cyc + 1; ac.wd = !rwv && inr; ac.ae = !inr;
    ackq.push_back(ac);
    if (rwv) begin
      rr.inst = k; rr.due = cyc + lat(k); rr.data = exp;
      rdq.push_back(rr);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      en = '0;
    end
  endtask

  // Count cycles with MemReady low from rst_n release until ready, bounded.
  task automatic count_init(input logic [2:0] sel);
    int cnt [3];
    cnt = '{0, 0, 0};
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 3; k++) if (sel[k] && !rdy[k]) cnt[k]++;
      if ((rdy & sel) == sel) break;
      @(posedge clk); #2;
    end
    for (int k = 0; k < 3; k++) if (sel[k]) chk("init_cycles", k, cnt[k], dep(k));
  endtask

  logic [255:0] aa, be_exp;

  initial begin
    rst_n = '0; en = '0; rw = 1'b0; addr = '0; din = '0; be = '0;
    nvec = 0; nerr = 0; mon_en = 0;
    last[0] = '0; last[1] = '0; last[2] = '0;
    aa = 256'hAA;
    be_exp = 256'hFFFF;
    be_exp = ~(be_exp << 32);

    repeat (2) @(posedge clk);
    #2;
    mon_en = 1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", k, rdy[k], 0);
      chk("rst_rvalid", k, rv[k], 0);
      chk("rst_wdone", k, wd[k], 0);
      chk("rst_aerr", k, ae[k], 0);
      chk("rst_dout", k, dout[k], 0);
    end
    rst_n = '1;
    count_init(3'b111);

    // Cleared memory, walking pattern, byte enables (DEPTH 128, RD_LAT 1)
    for (int i = 0; i < 128; i++) req(0, 1'b1, 7'(i), '0, '0, '0);
    for (int j = 0; j < 32; j++) req(0, 1'b0, 7'(j % 8), aa << (8 * j), '1, '0);
    for (int i = 0; i < 8; i++) req(0, 1'b1, 7'(i), '0, '0, aa << (8 * (24 + i)));
    req(0, 1'b0, 7'd5, '1, '1, '0);
    req(0, 1'b0, 7'd5, '0, 32'h0000_0010, '0);
    req(0, 1'b0, 7'd5, '0, 32'h0000_0020, '0);
    req(0, 1'b0, 7'd5, '0, 32'h0000_0000, '0);
    req(0, 1'b1, 7'd5, '0, '0, be_exp);
    idle(3);

    // Latency/ordering, read-after-write, out-of-range (DEPTH 100, RD_LAT 3)
    req(1, 1'b0, 7'd1, 256'h1111, '1, '0);
    req(1, 1'b0, 7'd2, 256'h2222, '1, '0);
    req(1, 1'b0, 7'd3, 256'h3333, '1, '0);
    req(1, 1'b1, 7'd1, '0, '0, 256'h1111);
    req(1, 1'b1, 7'd2, '0, '0, 256'h2222);
    req(1, 1'b1, 7'd3, '0, '0, 256'h3333);
    req(1, 1'b0, 7'd4, 256'h4444, '1, '0);
    req(1, 1'b1, 7'd4, '0, '0, 256'h4444);
    req(1, 1'b0, 7'd99, 256'h9999, '1, '0);
    req(1, 1'b1, 7'd99, '0, '0, 256'h9999);
    req(1, 1'b0, 7'd120, '1, '1, '0);
    req(1, 1'b0, 7'd100, '1, '1, '0);
    req(1, 1'b1, 7'd20, '0, '0, '0);
    req(1, 1'b1, 7'd56, '0, '0, '0);
    req(1, 1'b1, 7'd127, '0, '0, '0);
    req(1, 1'b1, 7'd100, '0, '0, '0);
    req(1, 1'b1, 7'd99, '0, '0, 256'h9999);
    idle(6);

    // Reset with two reads in flight (DEPTH 16, RD_LAT 4)
    req(2, 1'b0, 7'd3, 256'hC3, '1, '0);
    req(2, 1'b1, 7'd3, '0, '0, 256'hC3);
    idle(6);
    req(2, 1'b0, 7'd7, 256'hC7, '1, '0);
    req(2, 1'b1, 7'd7, '0, '0, 256'hC7);
    req(2, 1'b1, 7'd3, '0, '0, 256'hC3);
    @(posedge clk); #2;
    en = '0;
    rst_n[2] = 1'b0;
    for (int i = rdq.size() - 1; i >= 0; i--) if (rdq[i].inst == 2) rdq.delete(i);
    @(posedge clk); #2;
    rst_n[2] = 1'b1;
    last[2] = '0;
    count_init(3'b100);
    req(2, 1'b1, 7'd7, '0, '0, '0);
    req(2, 1'b1, 7'd3, '0, '0, '0);
    idle(8);

    chk("rd_queue_drained", 0, rdq.size(), 0);
    chk("ack_queue_drained", 0, ackq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout at cycle %0d: got no finish, expected completion", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
